// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
// Issues one LB/LH/LW/LBU/LHU/SB/SH/SW at a time to a variable-latency data memory.
// Misaligned or illegal accesses never reach memory and are reported as faults.
// Non-memory ops pass through with one cycle of latency.
package memory_stage_pkg;

  typedef struct packed {
    logic [31:0] decoded_instruction;
    logic [31:0] alu_result;
    logic [31:0] rs2_value;
    logic [31:0] branch_target;
  } execute_to_memory_t;

  typedef struct packed {
    logic [31:0] decoded_instruction;
    logic [31:0] alu_result;
    logic [31:0] branch_target;
    logic [31:0] data_from_memory;
  } memory_to_writeback_t;

endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  execute_to_memory_t    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output memory_to_writeback_t  out_data,
  output logic                  out_mem_fault,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] OUT_HOLD = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [1:0]            r_state;
  memory_to_writeback_t  r_out;
  logic                  r_fault;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_is_load;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [1:0]            w_addr_lo;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_fault;
  logic [3:0]            w_wstrb;
  logic [31:0]           w_wdata;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [15:0]           w_shifted;
  logic [31:0]           w_load_data;

  assign w_opcode   = in_data.decoded_instruction[6:0];
  assign w_funct3   = in_data.decoded_instruction[14:12];
  assign w_addr_lo  = in_data.alu_result[1:0];
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_addr     = {in_data.alu_result[ADDR_WIDTH-1:2], 2'b00};

  // Decode the incoming access: alignment/funct3 legality, byte enables and replicated store data.
  always_comb begin
    w_fault = 1'b0;
    w_wstrb = 4'h0;
    w_wdata = 32'h0;
    if (w_is_load) begin
      case (w_funct3)
        3'd0, 3'd4: w_fault = 1'b0;
        3'd1, 3'd5: w_fault = w_addr_lo[0];
        3'd2:       w_fault = (w_addr_lo != 2'b00);
        default:    w_fault = 1'b1;
      endcase
    end else if (w_is_store) begin
      case (w_funct3)
        3'd0: begin
          w_wstrb = 4'(4'b0001 << w_addr_lo);
          w_wdata = {4{in_data.rs2_value[7:0]}};
        end
        3'd1: begin
          w_fault = w_addr_lo[0];
          w_wstrb = 4'(4'b0011 << w_addr_lo);
          w_wdata = {2{in_data.rs2_value[15:0]}};
        end
        3'd2: begin
          w_fault = (w_addr_lo != 2'b00);
          w_wstrb = 4'hF;
          w_wdata = in_data.rs2_value;
        end
        default: w_fault = 1'b1;
      endcase
    end
  end

  assign w_shifted = 16'(dmem_rdata >> {r_addr_lo, 3'b000});

  // Select and extend the loaded byte/half/word from the returned memory word.
  always_comb begin
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'd1:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd4:    w_load_data = {24'h0, w_shifted[7:0]};
      3'd5:    w_load_data = {16'h0, w_shifted[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // Transaction FSM: accept in IDLE, wait for memory, hold the result until writeback takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_fault   <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_is_load <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_out.decoded_instruction <= in_data.decoded_instruction;
            r_out.alu_result          <= in_data.alu_result;
            r_out.branch_target       <= in_data.branch_target;
            r_out.data_from_memory    <= 32'h0;
            r_is_load                 <= w_is_load;
            r_funct3                  <= w_funct3;
            r_addr_lo                 <= w_addr_lo;
            r_fault                   <= w_fault;
            if ((w_is_load || w_is_store) && !w_fault) begin
              r_req   <= 1'b1;
              r_we    <= w_is_store;
              r_addr  <= w_addr;
              r_wdata <= w_wdata;
              r_wstrb <= w_wstrb;
              r_state <= MEM_WAIT;
            end else begin
              r_state <= OUT_HOLD;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_rvalid) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (r_is_load) begin
              r_out.data_from_memory <= w_load_data;
            end
            r_state <= OUT_HOLD;
          end
        end
        OUT_HOLD: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign out_valid     = (r_state == OUT_HOLD);
  assign out_data      = r_out;
  assign out_mem_fault = r_fault;
  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_wdata    = r_wdata;
  assign dmem_wstrb    = r_wstrb;

endmodule
